if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the branch unit's PC-source select and IF flush, plus the hazard unit's stall.
- Drives the instruction-memory address and feeds the decode stage with pc, pc+4, instruction and a valid bit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) inserted into IF/ID on reset or flush.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mux_to_pc  input  2  PC source from branch unit: 00 PC+4, 01 branch_target, 10 jalr_target, 11 reserved.
- IF_Flush  input  1  squash the instruction being fetched this cycle.
- stall  input  1  hazard unit load-use stall; hold PC and IF/ID.
- branch_target  input  32  PC-relative target (branch/JAL), computed in ID/EX.
- jalr_target  input  32  rs1+imm target for JALR.
- imem_rdata  input  32  instruction word at imem_addr; combinational read, same cycle.
- imem_addr  output  32  current PC; equals pc register.
- IF_ID_pc  output  32  PC of instruction held in IF/ID.
- IF_ID_pc_plus4  output  32  IF_ID_pc + 4.
- IF_ID_instr  output  32  instruction held in IF/ID.
- IF_ID_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
- misalign  output  1  registered one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Reset (synchronous, checked first each edge):
  - pc = RESET_PC; IF_ID_pc = 0; IF_ID_pc_plus4 = 0.
  - IF_ID_instr = NOP_INSTR; IF_ID_valid = 0; misalign = 0; counters (if present) = 0.
  - Reset asserted mid-stall or mid-redirect overrides everything.
- Next-PC select:
  - 00 → pc+4.
  - 01 → branch_target.
  - 10 → {jalr_target[31:1],1'b0}, bit0 cleared per RISC-V.
  - 11 → pc+4.
  - All additions are 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Redirect = (mux_to_pc == 01 or 10).
- Priority each edge: reset > redirect/flush > stall > normal advance.
- Normal (no reset, no redirect, IF_Flush=0, stall=0):
  - pc <= next_pc.
  - IF_ID_pc <= pc; IF_ID_pc_plus4 <= pc+4; IF_ID_instr <= imem_rdata; IF_ID_valid <= 1.
- Stall=1, no redirect, IF_Flush=0: pc and all IF/ID outputs hold their values. imem_addr is unchanged, so the same word is refetched next cycle.
- Redirect or IF_Flush=1:
  - pc <= next_pc, even if stall=1. A resolved control hazard beats a load-use stall; the stalled younger instruction is wrong-path.
  - IF_ID_instr <= NOP_INSTR; IF_ID_valid <= 0; IF_ID_pc and IF_ID_pc_plus4 <= 0.
- IF_Flush=1 with mux_to_pc=00 (not produced by the branch unit, but legal): flush IF/ID and advance pc to pc+4.
- misalign:
  - Registered on the edge where a redirect is taken and the selected target has bit1 set; otherwise 0 next cycle.
  - The PC still loads the misaligned target; trap handling is downstream.
- Latency: a redirect presented in cycle N gives imem_addr = target in cycle N+1. The first valid IF/ID after a redirect appears in cycle N+2.
- No combinational path from inputs to IF_ID_* outputs. imem_addr is a direct register output.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - cnt_fetch: increments on each normal advance.
  - cnt_stall: increments on each held cycle.
  - cnt_flush: increments on each redirect/flush cycle.
- Counters are reset to 0, saturate at 32'hFFFF_FFFF and never wrap.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, mux_to_pc=00, imem_rdata=addr-tagged words → imem_addr 0,4,8,12 in successive cycles; IF_ID_pc lags by one cycle; IF_ID_valid=1 from the 2nd cycle.
- At pc=0x10, mux_to_pc=01, IF_Flush=1, branch_target=0x100 for one cycle → next imem_addr=0x100; IF_ID_instr=0x00000013 and valid=0 for one cycle; then IF_ID_pc=0x100, valid=1.
- mux_to_pc=10, jalr_target=0x203 → pc=0x202, misalign pulses 1 for exactly one cycle; jalr_target=0x201 → pc=0x200, no misalign.
- stall=1 for 2 cycles at pc=0x24 → imem_addr stays 0x24 and IF/ID is frozen; on release pc advances to 0x28.
- stall=1 and mux_to_pc=01, IF_Flush=1 with branch_target=0x40 in the same cycle → pc=0x40 and IF/ID becomes a bubble (redirect wins).
- reset asserted during a stall with pc=0x80 → next cycle pc=RESET_PC, IF_ID_valid=0, misalign=0; RESET_PC=0x1000 override is honoured.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mux_to_pc,
    input  logic        IF_Flush,
    input  logic        stall,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc_plus4,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic        misalign
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] cnt_fetch,
    output logic [31:0] cnt_stall,
    output logic [31:0] cnt_flush
`endif
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        squash;
    logic        hold;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign redirect  = (mux_to_pc == 2'b01) || (mux_to_pc == 2'b10);
    // A resolved control hazard beats a load-use stall: the stalled
    // younger instruction is on the wrong path anyway.
    assign squash    = redirect || IF_Flush;
    assign hold      = stall && !squash;

    // Next-PC select; JALR clears bit0, reserved encoding falls back to pc+4
    always_comb begin
        next_pc = pc_plus4;
        case (mux_to_pc)
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = {jalr_target[31:1], 1'b0};
            default: next_pc = pc_plus4;
        endcase
    end

    // PC register, IF/ID register and misalign pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            IF_ID_pc       <= 32'd0;
            IF_ID_pc_plus4 <= 32'd0;
            IF_ID_instr    <= NOP_INSTR;
            IF_ID_valid    <= 1'b0;
            misalign       <= 1'b0;
        end else begin
            // Misaligned targets still load; trapping happens downstream
            misalign <= redirect && next_pc[1];
            if (squash) begin
                pc             <= next_pc;
                IF_ID_pc       <= 32'd0;
                IF_ID_pc_plus4 <= 32'd0;
                IF_ID_instr    <= NOP_INSTR;
                IF_ID_valid    <= 1'b0;
            end else if (!hold) begin
                pc             <= next_pc;
                IF_ID_pc       <= pc;
                IF_ID_pc_plus4 <= pc_plus4;
                IF_ID_instr    <= imem_rdata;
                IF_ID_valid    <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating event counters: fetch, held cycle, squash
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_fetch <= 32'd0;
            cnt_stall <= 32'd0;
            cnt_flush <= 32'd0;
        end else begin
            if (squash && cnt_flush != 32'hFFFF_FFFF)
                cnt_flush <= cnt_flush + 32'd1;
            if (hold && cnt_stall != 32'hFFFF_FFFF)
                cnt_stall <= cnt_stall + 32'd1;
            if (!squash && !hold && cnt_fetch != 32'hFFFF_FFFF)
                cnt_fetch <= cnt_fetch + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; a second instance checks a RESET_PC override.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mux_to_pc;
    logic        IF_Flush;
    logic        stall;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] imem_rdata, imem_rdata2;
    logic [31:0] imem_addr, IF_ID_pc, IF_ID_pc_plus4, IF_ID_instr;
    logic        IF_ID_valid, misalign;
    logic [31:0] imem_addr2, IF_ID_pc2, IF_ID_pc_plus42, IF_ID_instr2;
    logic        IF_ID_valid2, misalign2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_fetch, cnt_stall, cnt_flush;
    logic [31:0] cnt_fetch2, cnt_stall2, cnt_flush2;
`endif

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] TAG = 32'hC000_0000;

    always #5 clk = ~clk;

    // Instruction memory returns address-tagged words
    assign imem_rdata  = TAG | imem_addr;
    assign imem_rdata2 = TAG | imem_addr2;

    if_stage dut (
        .clk(clk), .reset(reset), .mux_to_pc(mux_to_pc), .IF_Flush(IF_Flush),
        .stall(stall), .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .IF_ID_pc(IF_ID_pc),
        .IF_ID_pc_plus4(IF_ID_pc_plus4), .IF_ID_instr(IF_ID_instr),
        .IF_ID_valid(IF_ID_valid), .misalign(misalign)
`ifdef IF_PERF_CNT_EN
        , .cnt_fetch(cnt_fetch), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
`endif
    );

    if_stage #(.RESET_PC(32'h0000_1000)) dut2 (
        .clk(clk), .reset(reset), .mux_to_pc(mux_to_pc), .IF_Flush(IF_Flush),
        .stall(stall), .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_rdata(imem_rdata2), .imem_addr(imem_addr2), .IF_ID_pc(IF_ID_pc2),
        .IF_ID_pc_plus4(IF_ID_pc_plus42), .IF_ID_instr(IF_ID_instr2),
        .IF_ID_valid(IF_ID_valid2), .misalign(misalign2)
`ifdef IF_PERF_CNT_EN
        , .cnt_fetch(cnt_fetch2), .cnt_stall(cnt_stall2), .cnt_flush(cnt_flush2)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        mux_to_pc = 2'b00; IF_Flush = 1'b0; stall = 1'b0;
        branch_target = 32'd0; jalr_target = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        step(); step();
        total++; if (imem_addr !== 32'd0) $display("FAIL rst_pc got %h exp %h", imem_addr, 32'd0); else passed++;
        total++; if (IF_ID_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", IF_ID_valid); else passed++;
        total++; if (IF_ID_instr !== NOP) $display("FAIL rst_instr got %h exp %h", IF_ID_instr, NOP); else passed++;
        total++; if (IF_ID_pc !== 32'd0 || IF_ID_pc_plus4 !== 32'd0) $display("FAIL rst_ifid_pc got %h/%h exp 0/0", IF_ID_pc, IF_ID_pc_plus4); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL rst_misalign got %b exp 0", misalign); else passed++;
        total++; if (imem_addr2 !== 32'h0000_1000) $display("FAIL rst_pc_override got %h exp %h", imem_addr2, 32'h0000_1000); else passed++;
`ifdef IF_PERF_CNT_EN
        total++; if ({cnt_fetch, cnt_stall, cnt_flush} !== 96'd0) $display("FAIL rst_cnt got %h/%h/%h exp 0", cnt_fetch, cnt_stall, cnt_flush); else passed++;
`endif
    endtask

    task automatic test_sequential;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            total++; if (imem_addr !== 32'(4*k)) $display("FAIL seq_pc[%0d] got %h exp %h", k, imem_addr, 32'(4*k)); else passed++;
            total++;
            if (IF_ID_pc !== 32'(4*(k-1)) || IF_ID_pc_plus4 !== 32'(4*k) ||
                IF_ID_instr !== (TAG | 32'(4*(k-1))) || IF_ID_valid !== 1'b1)
                $display("FAIL seq_ifid[%0d] got pc=%h p4=%h i=%h v=%b exp pc=%h v=1",
                         k, IF_ID_pc, IF_ID_pc_plus4, IF_ID_instr, IF_ID_valid, 32'(4*(k-1)));
            else passed++;
        end
    endtask

    // pc is 0x10 on entry
    task automatic test_branch;
        mux_to_pc = 2'b01; IF_Flush = 1'b1; branch_target = 32'h100;
        step();
        idle_inputs();
        total++; if (imem_addr !== 32'h100) $display("FAIL br_pc got %h exp %h", imem_addr, 32'h100); else passed++;
        total++; if (IF_ID_instr !== NOP || IF_ID_valid !== 1'b0 || IF_ID_pc !== 32'd0)
            $display("FAIL br_bubble got i=%h v=%b pc=%h exp i=%h v=0 pc=0", IF_ID_instr, IF_ID_valid, IF_ID_pc, NOP);
        else passed++;
        step();
        total++; if (IF_ID_pc !== 32'h100 || IF_ID_valid !== 1'b1 || IF_ID_instr !== (TAG | 32'h100) || imem_addr !== 32'h104)
            $display("FAIL br_after got pc=%h v=%b i=%h a=%h exp pc=100 v=1 a=104", IF_ID_pc, IF_ID_valid, IF_ID_instr, imem_addr);
        else passed++;
    endtask

    task automatic test_jalr;
        mux_to_pc = 2'b10; jalr_target = 32'h203;
        step();
        idle_inputs();
        total++; if (imem_addr !== 32'h202) $display("FAIL jalr_pc got %h exp %h", imem_addr, 32'h202); else passed++;
        total++; if (misalign !== 1'b1) $display("FAIL jalr_mis_pulse got %b exp 1", misalign); else passed++;
        step();
        total++; if (misalign !== 1'b0) $display("FAIL jalr_mis_clear got %b exp 0", misalign); else passed++;
        total++; if (IF_ID_pc !== 32'h202 || IF_ID_valid !== 1'b1 || imem_addr !== 32'h206)
            $display("FAIL jalr_after got pc=%h v=%b a=%h exp 202/1/206", IF_ID_pc, IF_ID_valid, imem_addr);
        else passed++;
        mux_to_pc = 2'b10; jalr_target = 32'h201;
        step();
        idle_inputs();
        total++; if (imem_addr !== 32'h200) $display("FAIL jalr2_pc got %h exp %h", imem_addr, 32'h200); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL jalr2_mis got %b exp 0", misalign); else passed++;
    endtask

    task automatic test_stall;
        mux_to_pc = 2'b01; branch_target = 32'h20;
        step();
        idle_inputs();
        step();   // pc=0x24, IF/ID holds 0x20
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (imem_addr !== 32'h24) $display("FAIL stall_pc[%0d] got %h exp %h", k, imem_addr, 32'h24); else passed++;
            total++; if (IF_ID_pc !== 32'h20 || IF_ID_pc_plus4 !== 32'h24 || IF_ID_instr !== (TAG | 32'h20) || IF_ID_valid !== 1'b1)
                $display("FAIL stall_ifid[%0d] got pc=%h p4=%h i=%h v=%b exp 20/24/c0000020/1", k, IF_ID_pc, IF_ID_pc_plus4, IF_ID_instr, IF_ID_valid);
            else passed++;
        end
`ifdef IF_PERF_CNT_EN
        total++; if (cnt_stall !== 32'd2) $display("FAIL cnt_stall got %0d exp 2", cnt_stall); else passed++;
`endif
        stall = 1'b0;
        step();
        total++; if (imem_addr !== 32'h28 || IF_ID_pc !== 32'h24 || IF_ID_valid !== 1'b1)
            $display("FAIL stall_release got a=%h pc=%h v=%b exp 28/24/1", imem_addr, IF_ID_pc, IF_ID_valid);
        else passed++;
    endtask

    task automatic test_stall_redirect;
        stall = 1'b1; mux_to_pc = 2'b01; IF_Flush = 1'b1; branch_target = 32'h40;
        step();
        idle_inputs();
        total++; if (imem_addr !== 32'h40) $display("FAIL stred_pc got %h exp %h", imem_addr, 32'h40); else passed++;
        total++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP || IF_ID_pc !== 32'd0 || IF_ID_pc_plus4 !== 32'd0)
            $display("FAIL stred_bubble got v=%b i=%h pc=%h p4=%h exp 0/%h/0/0", IF_ID_valid, IF_ID_instr, IF_ID_pc, IF_ID_pc_plus4, NOP);
        else passed++;
        step();   // pc 0x44
        IF_Flush = 1'b1;
        step();
        IF_Flush = 1'b0;
        total++; if (imem_addr !== 32'h48 || IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP)
            $display("FAIL flush_only got a=%h v=%b i=%h exp 48/0/%h", imem_addr, IF_ID_valid, IF_ID_instr, NOP);
        else passed++;
    endtask

    task automatic test_wrap;
        mux_to_pc = 2'b01; branch_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        total++; if (misalign !== 1'b0) $display("FAIL wrap_mis got %b exp 0", misalign); else passed++;
        step();
        total++; if (imem_addr !== 32'd0 || IF_ID_pc !== 32'hFFFF_FFFC || IF_ID_pc_plus4 !== 32'd0)
            $display("FAIL wrap got a=%h pc=%h p4=%h exp 0/fffffffc/0", imem_addr, IF_ID_pc, IF_ID_pc_plus4);
        else passed++;
        mux_to_pc = 2'b01; branch_target = 32'h302;
        step();
        idle_inputs();
        total++; if (misalign !== 1'b1 || imem_addr !== 32'h302)
            $display("FAIL br_mis got m=%b a=%h exp 1/302", misalign, imem_addr);
        else passed++;
        mux_to_pc = 2'b11;
        step();
        mux_to_pc = 2'b00;
        total++; if (imem_addr !== 32'h306 || misalign !== 1'b0 || IF_ID_valid !== 1'b1)
            $display("FAIL sel11 got a=%h m=%b v=%b exp 306/0/1", imem_addr, misalign, IF_ID_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_stall;
        mux_to_pc = 2'b01; branch_target = 32'h80;
        step();
        idle_inputs();
        stall = 1'b1;
        step();
        total++; if (imem_addr !== 32'h80) $display("FAIL pre_rst_pc got %h exp %h", imem_addr, 32'h80); else passed++;
        reset = 1'b1; mux_to_pc = 2'b01; branch_target = 32'h302;
        step();
        total++; if (imem_addr !== 32'd0 || IF_ID_valid !== 1'b0 || misalign !== 1'b0 || IF_ID_instr !== NOP)
            $display("FAIL rst_stall got a=%h v=%b m=%b i=%h exp 0/0/0/%h", imem_addr, IF_ID_valid, misalign, IF_ID_instr, NOP);
        else passed++;
        total++; if (imem_addr2 !== 32'h0000_1000) $display("FAIL rst_stall_override got %h exp %h", imem_addr2, 32'h0000_1000); else passed++;
        reset = 1'b0;
        idle_inputs();
        step();
        total++; if (imem_addr2 !== 32'h0000_1004 || IF_ID_pc2 !== 32'h0000_1000 || IF_ID_valid2 !== 1'b1)
            $display("FAIL override_run got a=%h pc=%h v=%b exp 1004/1000/1", imem_addr2, IF_ID_pc2, IF_ID_valid2);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jalr();
        test_stall();
        test_stall_redirect();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
